clock_rate_sequencer: RTL and testbench
=======================================

// Module: clock_rate_sequencer
// PURPOSE
//   Run/pause and speed-step controller for the board's clock-divider datapath.
//   Turns the KEY pushbuttons into clean press events and steps through a table of four divisors.
//   Runs the divide counter and emits a one-cycle tick enable plus a 50% clock_out.
//   Sits between the KEY inputs and all rate-driven logic (counters, displays); divisor changes are glitch-free.
// PARAMETERS
//   DIV_W            32         width of divisor/counter
//   DIV0             5_000_000  clk cycles per tick, speed 0 (reset speed)
//   DIV1             2_500_000  clk cycles per tick, speed 1
//   DIV2             1_000_000  clk cycles per tick, speed 2
//   DIV3             500_000    clk cycles per tick, speed 3
//   DEBOUNCE_CYCLES  200_000    stable cycles required per key level (DEBOUNCE_EN only)
// PORTS
//   clk        in   1      system clock, all logic on posedge
//   reset      in   1      asynchronous, active-high reset
//   KEY        in   2      active-low pushbuttons: [0] run/pause toggle, [1] speed step
//   tick       out  1      one-cycle high pulse once per divisor period
//   clock_out  out  1      toggles on every tick (period = 2*divisor)
//   running    out  1      1 = counting, 0 = paused
//   speed_sel  out  2      currently applied speed index
//   divisor    out  DIV_W  currently applied divisor value
// BEHAVIOUR
// - Reset (async, immediate): state RUN, running=1, speed_sel=0, divisor=DIV0, pending_sel=0.
//   Also counter=0, tick=0, clock_out=0, and key sync/debounce state = released (1).
// - Key path: each KEY bit passes a 2-FF synchronizer, then the optional debounce filter.
//   A press event is a single-cycle 1->0 transition of the filtered level; release produces no event.
// - States: RUN, PAUSED.
//   - RUN + run/pause event -> PAUSED.
//   - PAUSED + run/pause event -> RUN.
// - RUN: counter increments each clk. At counter==divisor-1, same edge:
//   counter<=0, tick<=1 (tick is registered, high exactly one cycle), clock_out<=~clock_out.
//   First tick goes high after the DIV0-th rising edge following reset release.
// - PAUSED: counter, clock_out and divisor are held; tick=0.
//   Resuming continues from the held counter value; no tick on resume.
// - Speed event: pending_sel <= pending_sel+1, mod 4 (3->0).
//   - In RUN the change is applied only at the wrap edge:
//     speed_sel<=pending_sel and divisor<=DIVn(pending_sel) on the same edge as counter<=0.
//     The current period therefore always completes at the old rate.
//   - Multiple events before a wrap accumulate; only the final value is applied.
//   - In PAUSED the change is applied on the next edge, and counter<=0.
// - Simultaneous run/pause and speed events in one cycle: both act.
//   The speed change follows the rules of the state held before that edge.
// - Divisor guard: any table entry < 2 is clamped to 2, so tick is never held constantly high.
// - Counter compare is full DIV_W; no other overflow is possible.
// CONFIGURATION
//   DEBOUNCE_EN defined: each synced key bit drives a counter.
//     The filtered level changes only after the raw level differs from it for DEBOUNCE_CYCLES consecutive clks.
//     Any bounce resets the count. Event latency = 2 sync + DEBOUNCE_CYCLES + 1 edge-detect cycles.
//   DEBOUNCE_EN undefined: the filtered level equals the 2-FF synced level.
//     Event latency = 3 clks. DEBOUNCE_CYCLES is ignored and its counter logic is not built.
// TESTING  (DIV0=4, DIV1=3, DIV2=2, DIV3=6, DEBOUNCE_CYCLES=3)
//   1. Release reset, KEY=2'b11 -> tick every 4 clks, clock_out period 8, speed_sel=0, running=1.
//   2. Speed press while counter=1 -> next tick still 4 clks after the previous one, then speed_sel=1, divisor=3, ticks every 3.
//   3. Four speed presses, one per period -> speed_sel steps 1,2,3,0; tick spacing 3,2,6,4.
//   4. Run/pause press with counter=2 -> running=0, no tick for 20 clks, clock_out held.
//      Second press -> running=1, tick after 2 more clks.
//   5. Reset asserted mid-period with clock_out=1 -> clock_out, tick, counter = 0 and speed_sel=0 without a clk edge.
//   6. DEBOUNCE_EN: a 2-clk KEY[1] low glitch gives no event; a 5-clk low gives exactly one.
//      Without the macro the 2-clk glitch gives one event.

Source files
------------

// File: rtl/clock_rate_sequencer_if.sv
// rtl/clock_rate_sequencer_if.sv - pushbutton inputs and rate outputs of the clock-rate sequencer
// master: the sequencer itself; slave: the board/keys side that drives KEY and consumes the rate.
interface clock_rate_sequencer_if #(
   parameter int DIV_W = 32
);
   logic [1:0]       KEY;
   logic             tick;
   logic             clock_out;
   logic             running;
   logic [1:0]       speed_sel;
   logic [DIV_W-1:0] divisor;

   modport master (
      input  KEY,
      output tick,
      output clock_out,
      output running,
      output speed_sel,
      output divisor
   );

   modport slave (
      output KEY,
      input  tick,
      input  clock_out,
      input  running,
      input  speed_sel,
      input  divisor
   );
endinterface

// File: rtl/clock_rate_sequencer.sv
// rtl/clock_rate_sequencer.sv - run/pause and speed-step controller driving a divide counter, tick and clock_out
// Optional key debounce filter is built when DEBOUNCE_EN is defined.
module clock_rate_sequencer #(
   parameter int          DIV_W = 32,
   parameter int unsigned DIV0  = 5_000_000,
   parameter int unsigned DIV1  = 2_500_000,
   parameter int unsigned DIV2  = 1_000_000,
   parameter int unsigned DIV3  = 500_000
`ifdef DEBOUNCE_EN
   ,
   parameter int unsigned DEBOUNCE_CYCLES = 200_000
`endif
) (
   input  logic                   clk,
   input  logic                   reset,
   clock_rate_sequencer_if.master bus
);

   // Entries below 2 would leave tick permanently high, so they are clamped.
   localparam logic [DIV_W-1:0] TAB0 = (DIV0 < 2) ? DIV_W'(2) : DIV_W'(DIV0);
   localparam logic [DIV_W-1:0] TAB1 = (DIV1 < 2) ? DIV_W'(2) : DIV_W'(DIV1);
   localparam logic [DIV_W-1:0] TAB2 = (DIV2 < 2) ? DIV_W'(2) : DIV_W'(DIV2);
   localparam logic [DIV_W-1:0] TAB3 = (DIV3 < 2) ? DIV_W'(2) : DIV_W'(DIV3);

   typedef enum logic {
      ST_RUN,
      ST_PAUSED
   } state_t;

   state_t           state;
   logic [1:0]       key_meta;
   logic [1:0]       key_sync;
   logic [1:0]       key_filt;
   logic [1:0]       key_prev;
   logic [1:0]       press;
   logic             run_ev;
   logic             speed_ev;
   logic             wrap;
   logic [DIV_W-1:0] counter;
   logic [DIV_W-1:0] divisor_q;
   logic             tick_q;
   logic             clock_out_q;
   logic             running_q;
   logic [1:0]       speed_sel_q;
   logic [1:0]       pending_sel;
   logic [1:0]       pending_next;

   function automatic logic [DIV_W-1:0] div_of(input logic [1:0] sel);
      case (sel)
         2'd0:    div_of = TAB0;
         2'd1:    div_of = TAB1;
         2'd2:    div_of = TAB2;
         default: div_of = TAB3;
      endcase
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_meta <= 2'b11;
         key_sync <= 2'b11;
      end else begin
         key_meta <= bus.KEY;
         key_sync <= key_meta;
      end
   end

`ifdef DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   for (genvar i = 0; i < 2; i++) begin : g_db
      logic [CNT_W-1:0] db_cnt;

      // The filtered level flips only after the synced level disagrees for DEBOUNCE_CYCLES clks in a row.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            db_cnt      <= '0;
            key_filt[i] <= 1'b1;
         end else if (key_sync[i] == key_filt[i]) begin
            db_cnt <= '0;
         end else if (db_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt      <= '0;
            key_filt[i] <= key_sync[i];
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end
`else
   assign key_filt = key_sync;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_prev <= 2'b11;
      end else begin
         key_prev <= key_filt;
      end
   end

   // Keys are active-low: a press is the falling edge of the filtered level.
   assign press        = key_prev & ~key_filt;
   assign run_ev       = press[0];
   assign speed_ev     = press[1];
   assign wrap         = (counter == divisor_q - 1'b1);
   assign pending_next = pending_sel + 2'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_RUN;
         running_q   <= 1'b1;
         speed_sel_q <= 2'd0;
         pending_sel <= 2'd0;
         divisor_q   <= TAB0;
         counter     <= '0;
         tick_q      <= 1'b0;
         clock_out_q <= 1'b0;
      end else begin
         tick_q <= 1'b0;
         if (speed_ev) begin
            pending_sel <= pending_next;
         end
         case (state)
            ST_RUN: begin
               // A new speed only takes effect at the wrap, so the running period finishes at the old rate.
               if (wrap) begin
                  counter     <= '0;
                  tick_q      <= 1'b1;
                  clock_out_q <= ~clock_out_q;
                  speed_sel_q <= pending_sel;
                  divisor_q   <= div_of(pending_sel);
               end else begin
                  counter <= counter + 1'b1;
               end
               if (run_ev) begin
                  state     <= ST_PAUSED;
                  running_q <= 1'b0;
               end
            end
            ST_PAUSED: begin
               if (speed_ev) begin
                  speed_sel_q <= pending_next;
                  divisor_q   <= div_of(pending_next);
                  counter     <= '0;
               end
               if (run_ev) begin
                  state     <= ST_RUN;
                  running_q <= 1'b1;
               end
            end
            default: begin
               state     <= ST_RUN;
               running_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.tick      = tick_q;
   assign bus.clock_out = clock_out_q;
   assign bus.running   = running_q;
   assign bus.speed_sel = speed_sel_q;
   assign bus.divisor   = divisor_q;

endmodule

// File: tb/tb_clock_rate_sequencer.sv
// tb/tb_clock_rate_sequencer.sv - directed-vector bench for clock_rate_sequencer (DIV 4/3/2/6, DEBOUNCE_CYCLES 3)
module tb_clock_rate_sequencer;
   localparam int DIV_W = 32;
`ifdef DEBOUNCE_EN
   localparam int PRESS_LOW  = 5;
   localparam int EV_LAT     = 6;
   localparam int SETTLE     = 8;
   localparam int GLITCH_SEL = 2;
   localparam int LONG_SEL   = 3;
`else
   localparam int PRESS_LOW  = 1;
   localparam int EV_LAT     = 3;
   localparam int SETTLE     = 0;
   localparam int GLITCH_SEL = 3;
   localparam int LONG_SEL   = 0;
`endif
   localparam int RESUME_EDGES = 4 - (EV_LAT % 4);

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   last_tick = 0;
   int   tick_gap = 0;
   int   tick_cnt = 0;

   clock_rate_sequencer_if #(.DIV_W(DIV_W)) bus ();

   clock_rate_sequencer #(
      .DIV_W(DIV_W), .DIV0(4), .DIV1(3), .DIV2(2), .DIV3(6)
`ifdef DEBOUNCE_EN
      , .DEBOUNCE_CYCLES(3)
`endif
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (reset) begin
         last_tick <= cyc;
      end else if (bus.tick) begin
         tick_gap  <= cyc - last_tick;
         last_tick <= cyc;
         tick_cnt  <= tick_cnt + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_tick(input string tag);
      int start;
      bit seen;
      seen = 1'b0;
      @(negedge clk);
      #1;
      start = tick_cnt;
      for (int i = 0; i < 64 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (tick_cnt != start) seen = 1'b1;
      end
      check({tag, "_seen"}, 32'(seen), 1);
   endtask

   task automatic press(input int idx, input int low);
      bus.KEY[idx] = 1'b0;
      step(low);
      bus.KEY[idx] = 1'b1;
      if (EV_LAT > low) step(EV_LAT - low);
   endtask

   task automatic edges_to_tick(input string tag, input int exp);
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         step(1);
         n++;
         if (bus.tick) break;
      end
      check(tag, n, exp);
   endtask

   int exp_sel[4] = '{2, 3, 0, 1};
   int exp_div[4] = '{2, 6, 4, 3};

   initial begin
      int   hits;
      logic saved;
      bus.KEY = 2'b11;
      step(2);
      check("rst_tick", bus.tick, 0);
      check("rst_clock_out", bus.clock_out, 0);
      check("rst_running", bus.running, 1);
      check("rst_speed_sel", bus.speed_sel, 0);
      check("rst_divisor", bus.divisor, 4);
      @(negedge clk);
      #1;
      reset = 1'b0;

      wait_tick("t1a");
      check("first_tick_gap", tick_gap, 4);
      check("clk_out_rise", bus.clock_out, 1);
      step(1);
      check("tick_one_cycle", bus.tick, 0);
      wait_tick("t1b");
      check("tick_gap_div0", tick_gap, 4);
      check("clk_out_fall", bus.clock_out, 0);
      check("run_speed_sel", bus.speed_sel, 0);
      check("run_running", bus.running, 1);

      press(0, PRESS_LOW);
      check("pause_running", bus.running, 0);
      saved = bus.clock_out;
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (bus.tick) hits++;
      end
      check("pause_no_tick", hits, 0);
      check("pause_clk_out_held", bus.clock_out, 32'(saved));
      press(0, PRESS_LOW);
      check("resume_running", bus.running, 1);
      check("resume_no_tick", bus.tick, 0);
      edges_to_tick("resume_edges", RESUME_EDGES);

      press(1, PRESS_LOW);
      check("spd_not_yet", bus.speed_sel, 0);
      wait_tick("spd_apply");
      check("spd_old_period", tick_gap, 4);
      check("spd_sel_1", bus.speed_sel, 1);
      check("spd_div_3", bus.divisor, 3);
      wait_tick("spd_new");
      check("spd_gap_3", tick_gap, 3);

      for (int k = 0; k < 4; k++) begin
         step(SETTLE);
         press(1, PRESS_LOW);
         wait_tick("step_apply");
         check("step_sel", bus.speed_sel, exp_sel[k]);
         check("step_div", bus.divisor, exp_div[k]);
         wait_tick("step_gap");
         check("step_gap", tick_gap, exp_div[k]);
      end

      step(SETTLE);
      press(0, PRESS_LOW);
      check("p2_running", bus.running, 0);
      step(SETTLE);
      press(1, PRESS_LOW);
      check("paused_spd_sel", bus.speed_sel, 2);
      check("paused_spd_div", bus.divisor, 2);
      step(SETTLE);
      press(0, PRESS_LOW);
      edges_to_tick("paused_spd_restart", 2);

      step(SETTLE);
      press(0, PRESS_LOW);
      step(SETTLE + 4);
      bus.KEY[1] = 1'b0;
      step(2);
      bus.KEY[1] = 1'b1;
      step(12);
      check("glitch_sel", bus.speed_sel, GLITCH_SEL);
      bus.KEY[1] = 1'b0;
      step(5);
      bus.KEY[1] = 1'b1;
      step(12);
      check("long_press_sel", bus.speed_sel, LONG_SEL);
      press(1, PRESS_LOW);
      step(SETTLE);
      press(1, PRESS_LOW);
      step(SETTLE);
      press(0, PRESS_LOW);

      wait_tick("pre_rst_a");
      if (!bus.clock_out) wait_tick("pre_rst_b");
      check("pre_rst_clk_out", bus.clock_out, 1);
      step(1);
      #2;
      reset = 1'b1;
      #1;
      check("arst_clock_out", bus.clock_out, 0);
      check("arst_tick", bus.tick, 0);
      check("arst_speed_sel", bus.speed_sel, 0);
      check("arst_divisor", bus.divisor, 4);
      check("arst_running", bus.running, 1);
      step(2);
      @(negedge clk);
      #1;
      reset = 1'b0;
      wait_tick("post_rst");
      check("post_rst_gap", tick_gap, 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end
endmodule
